// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types and widths for the RO-PUF challenge sweeper.
package puf_pkg;

  localparam int CHAL_W   = 6;
  localparam int RESP_W   = 8;
  localparam int NUM_CHAL = 1 << CHAL_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    CLEAR   = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4,
    CAPTURE = 3'd5,
    NEXT    = 3'd6
  } state_t;

  typedef struct packed {
    logic [CHAL_W-1:0] chal;
    logic [RESP_W-1:0] resp;
  } crp_t;

endpackage

// File: rtl/puf_challenge_sweeper_crp_table.sv
// rtl/puf_challenge_sweeper_crp_table.sv - challenge/response table, one write port, registered read.
// Read-during-write to the same entry returns the previous contents.
module crp_table
  import puf_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  crp_t              wr_i,
  input  logic [CHAL_W-1:0] rd_addr_i,
  output logic [RESP_W-1:0] rd_data_o
);

  logic [RESP_W-1:0] mem_q [NUM_CHAL];
  logic [RESP_W-1:0] rd_data_q;

  // Async clear so a mid-sweep reset leaves no stale responses behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CHAL; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_i.chal] <= wr_i.resp;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/puf_challenge_sweeper.sv
// rtl/puf_challenge_sweeper.sv - sweeps every challenge through the RO-PUF core and records responses.
// FSM plus settle/timeout counters; responses land in crp_table for host readback.
module puf_challenge_sweeper
  import puf_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [CHAL_W-1:0] challenge_o,
  output logic              meas_rst_o,
  input  logic              meas_done_i,
  input  logic [RESP_W-1:0] response_i,
  input  logic [CHAL_W-1:0] rd_addr_i,
  output logic [RESP_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_err_o,
  output logic [CHAL_W-1:0] fail_chal_o
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic [CHAL_W-1:0] fail_q, fail_d;

  logic settle_last;
  logic tmo_last;
  logic chal_last;
  logic go;
  logic timeout_hit;
  logic tbl_we;
  crp_t tbl_wr;

  assign settle_last = (settle_q == SET_W'(SETTLE_CYCLES - 1));
  assign tmo_last    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign chal_last   = (chal_q == {CHAL_W{1'b1}});
  assign go          = (state_q == IDLE) && start_i && !abort_i;
  // A timeout only fires if this cycle would not otherwise make progress.
  assign timeout_hit = tmo_last && !abort_i &&
                       (((state_q == WAIT_LO) &&  meas_done_i) ||
                        ((state_q == WAIT_HI) && !meas_done_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = SETUP;
      SETUP:   if (settle_last) state_d = CLEAR;
      CLEAR:   state_d = WAIT_LO;
      WAIT_LO: begin
        if (!meas_done_i)  state_d = WAIT_HI;
        else if (tmo_last) state_d = IDLE;
      end
      WAIT_HI: begin
        if (meas_done_i)   state_d = CAPTURE;
        else if (tmo_last) state_d = IDLE;
      end
      CAPTURE: state_d = NEXT;
      NEXT:    state_d = chal_last ? IDLE : SETUP;
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    busy_o     = (state_q != IDLE);
    meas_rst_o = (state_q == CLEAR);
    tbl_we     = (state_q == CAPTURE) && !abort_i;
  end

  always_comb begin
    settle_d = (state_q == SETUP) ? settle_q + SET_W'(1) : '0;
    tmo_d    = ((state_q == WAIT_LO) || (state_q == WAIT_HI)) ? tmo_q + TMO_W'(1) : '0;
    chal_d   = chal_q;
    done_d   = done_q;
    terr_d   = terr_q;
    fail_d   = fail_q;
    if (go) begin
      chal_d = '0;
      done_d = 1'b0;
      terr_d = 1'b0;
    end
    if ((state_q == NEXT) && !abort_i) begin
      if (chal_last) begin
        done_d = 1'b1;
      end else begin
        chal_d = chal_q + CHAL_W'(1);
      end
    end
    if (timeout_hit) begin
      terr_d = 1'b1;
      fail_d = chal_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_q <= '0;
      tmo_q    <= '0;
      chal_q   <= '0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      fail_q   <= '0;
    end else begin
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      chal_q   <= chal_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      fail_q   <= fail_d;
    end
  end

  assign tbl_wr.chal = chal_q;
  assign tbl_wr.resp = response_i;

  crp_table u_crp_table (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (tbl_we),
    .wr_i      (tbl_wr),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  assign challenge_o   = chal_q;
  assign done_o        = done_q;
  assign timeout_err_o = terr_q;
  assign fail_chal_o   = fail_q;

endmodule
